// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte producers with round-robin
// arbitration. The arbiter latches the winning byte, pulses tx_start and the
// winner's gnt for one cycle, then follows the transmitter's tx_busy through
// acceptance and completion before it arbitrates again.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to build a watchdog. The
// watchdog aborts a frame the transmitter never accepts or never finishes.
// When the macro is undefined, the watchdog is not built and timeout_err is
// tied low.
//
// Build notes:
// - Every output is registered.
// - Reset is synchronous and active high.

module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       arb_busy,
    output logic                       timeout_err
);

    localparam int IW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    // After reset the pointer sits on the last requester, so the search
    // starts at requester 0.
    localparam logic [IW-1:0]      PTR_RESET = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] GNT_ONE   = NUM_REQ'(1);

    logic [1:0]         state_q,    state_d;
    logic [IW-1:0]      ptr_q,      ptr_d;
    logic [IW-1:0]      grant_id_q, grant_id_d;
    logic [DATA_W-1:0]  tx_data_q,  tx_data_d;
    logic [NUM_REQ-1:0] gnt_q,      gnt_d;
    logic               tx_start_q, tx_start_d;
    logic               arb_busy_q, arb_busy_d;

    logic               found;
    logic [IW-1:0]      winner;
    logic [IW-1:0]      cand;
    logic [DATA_W-1:0]  winner_byte;

    // Round-robin search: the first set req bit at ptr+1, ptr+2, ... wrapping
    // modulo NUM_REQ. ptr itself is checked last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IW'((int'(ptr_q) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign winner_byte = req_data[int'(winner)*DATA_W +: DATA_W];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          wd_expired;
    logic          timeout_q, timeout_d;

    // The count restarts on every new frame and advances once per wait
    // cycle. It reaches TIMEOUT_CYCLES-1 in the last wait cycle allowed.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == ST_ISSUE) begin
            wd_cnt_d = '0;
        end else if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) begin
            wd_cnt_d = wd_cnt_q + CW'(1);
        end
    end

    assign wd_expired = (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Watchdog count and the one-cycle abort flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Next-state logic.
    // - The IDLE decision loads the byte, the index and the one-cycle strobes
    //   together, so all of them are visible during ISSUE.
    // - ptr and grant_id already show the winner while ISSUE is active.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
        gnt_d      = '0;
        tx_start_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        timeout_d  = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d    = ST_ISSUE;
                    tx_data_d  = winner_byte;
                    ptr_d      = winner;
                    grant_id_d = winner;
                    gnt_d      = GNT_ONE << winner;
                    tx_start_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef UART_ARB_TIMEOUT_EN
        // Normal completion in the limit cycle takes precedence over the abort.
        if ((state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) && wd_expired &&
            !(state_q == ST_WAIT_DONE && !tx_busy)) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
        end
`endif

        arb_busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs. A reset discards any latched byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PTR_RESET;
            grant_id_q <= '0;
            tx_data_q  <= '0;
            gnt_q      <= '0;
            tx_start_q <= 1'b0;
            arb_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
            gnt_q      <= gnt_d;
            tx_start_q <= tx_start_d;
            arb_busy_q <= arb_busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign arb_busy = arb_busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter.
// - Requesters present bytes and withdraw them after the programmed number of
//   grants.
// - A transmitter model answers each tx_start with a busy window.
// - The expected grant order is queued as stimulus is applied and checked as
//   each tx_start appears.

module tb_uart_tx_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int DATA_W         = 8;
    localparam int TIMEOUT_CYCLES = 16;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         gnt;
    logic                       tx_start;
    logic [DATA_W-1:0]          tx_data;
    logic                       tx_busy;
    logic [1:0]                 grant_id;
    logic                       arb_busy;
    logic                       timeout_err;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int         goal      [NUM_REQ];
    int         start_cnt [NUM_REQ];
    logic [7:0] base      [NUM_REQ];
    int         granted   [NUM_REQ];

    int   xmit_late  = 0;
    int   xmit_len   = 12;
    bit   xmit_mute  = 1'b0;
    logic model_busy = 1'b0;
    logic force_busy = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    assign tx_busy = model_busy | force_busy;

    // A requester holds req while it still has frames to send. Its byte
    // steps by one after every grant.
    always_comb begin
        req      = '0;
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i]                = (granted[i] < goal[i]);
            req_data[i*8 +: 8]    = base[i] + 8'(granted[i] - start_cnt[i]);
        end
    end

    // Requesters consume their grants.
    initial begin
        for (int i = 0; i < NUM_REQ; i++) granted[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] === 1'b1) granted[i] = granted[i] + 1;
            end
        end
    end

    // Transmitter model: after tx_start, optionally delay, then stay busy.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && !xmit_mute) begin
                for (int k = 0; k < xmit_late; k++) @(negedge clk);
                model_busy = 1'b1;
                for (int k = 0; k < xmit_len; k++) begin
                    @(negedge clk);
                    if (reset) break;
                end
                model_busy = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushExpected(input int id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input int frames, input logic [7:0] b);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[i]) begin
                start_cnt[i] = granted[i];
                base[i]      = b + 8'(16 * i);
                goal[i]      = granted[i] + frames;
            end
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_gnt"},         32'(gnt),         32'd0);
        checkOutput({tag, "_tx_start"},    32'(tx_start),    32'd0);
        checkOutput({tag, "_tx_data"},     32'(tx_data),     32'd0);
        checkOutput({tag, "_grant_id"},    32'(grant_id),    32'd0);
        checkOutput({tag, "_arb_busy"},    32'(arb_busy),    32'd0);
        checkOutput({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;
    endtask

    task automatic waitStart();
        int n = 0;
        while (tx_start !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_start_in_time", 32'(n < 300), 32'd1);
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((exp_q.size() != 0 || arb_busy !== 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_idle_in_time", 32'(n < 2000), 32'd1);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every ISSUE cycle must match the oldest queued grant.
    always @(negedge clk) begin
        if (reset === 1'b0 && (tx_start === 1'b1 || gnt !== '0)) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_start", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("sb_tx_start", 32'(tx_start), 32'd1);
                checkOutput("sb_gnt",      32'(gnt),      32'd1 << mon_e.id);
                checkOutput("sb_tx_data",  32'(tx_data),  32'(mon_e.data));
                checkOutput("sb_grant_id", 32'(grant_id), 32'(mon_e.id));
            end
        end
    end

    // Global time limit so that the bench never hangs.
    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    // Directed test sequence.
    initial begin
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            goal[i]      = 0;
            start_cnt[i] = 0;
            base[i]      = 8'h00;
        end

        // Reset and first grant.
        doReset(3);
        @(negedge clk);
        checkOutput("idle_arb_busy", 32'(arb_busy), 32'd0);
        applyStimulus(4'b0001, 1, 8'hA5);
        pushExpected(0, 8'hA5);
        @(negedge clk);
        checkOutput("first_tx_start", 32'(tx_start), 32'd1);
        checkOutput("first_gnt",      32'(gnt),      32'b0001);
        checkOutput("first_tx_data",  32'(tx_data),  32'hA5);
        checkOutput("first_grant_id", 32'(grant_id), 32'd0);
        checkOutput("first_arb_busy", 32'(arb_busy), 32'd1);
        waitIdle();

        // Round-robin with all four requesters pending.
        doReset(2);
        applyStimulus(4'b1110, 1, 8'h00);
        applyStimulus(4'b0001, 2, 8'h00);
        pushExpected(0, 8'h00);
        pushExpected(1, 8'h10);
        pushExpected(2, 8'h20);
        pushExpected(3, 8'h30);
        pushExpected(0, 8'h01);
        waitIdle();

        // Skip idle requesters: grant 1 moves ptr to 1, then req=1001.
        doReset(2);
        applyStimulus(4'b0010, 1, 8'h40);
        pushExpected(1, 8'h50);
        waitIdle();
        applyStimulus(4'b1001, 1, 8'h40);
        pushExpected(3, 8'h70);
        pushExpected(0, 8'h40);
        waitIdle();

        // Late busy and immediate re-request.
        // - busy rises 5 cycles after tx_start and stays high for 6 cycles.
        // - The next ISSUE comes 2 cycles after busy falls.
        doReset(2);
        xmit_late = 5;
        xmit_len  = 6;
        applyStimulus(4'b0001, 2, 8'hC0);
        pushExpected(0, 8'hC0);
        pushExpected(0, 8'hC1);
        waitStart();
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            checkOutput($sformatf("late_tx_start_c%0d", c), 32'(tx_start), 32'(c == 13));
            checkOutput($sformatf("late_arb_busy_c%0d", c), 32'(arb_busy), 32'(c != 12));
        end
        waitIdle();
        xmit_late = 0;
        xmit_len  = 12;

        // Reset in WAIT_DONE discards the frame; requester 0 wins first after release.
        doReset(2);
        applyStimulus(4'b0010, 1, 8'h60);
        pushExpected(1, 8'h70);
        waitStart();
        repeat (4) @(negedge clk);
        checkOutput("midframe_arb_busy", 32'(arb_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("midframe_reset");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'b1111, 1, 8'h80);
        pushExpected(0, 8'h80);
        pushExpected(1, 8'h90);
        pushExpected(2, 8'hA0);
        pushExpected(3, 8'hB0);
        waitIdle();

        // The transmitter never raises busy for requester 0's frame.
        doReset(2);
        xmit_mute = 1'b1;
        applyStimulus(4'b0101, 1, 8'h00);
        pushExpected(0, 8'h00);
        pushExpected(2, 8'h20);
        waitStart();
`ifdef UART_ARB_TIMEOUT_EN
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            checkOutput($sformatf("wd_timeout_err_c%0d", c), 32'(timeout_err), 32'(c == 17));
            checkOutput($sformatf("wd_arb_busy_c%0d", c),    32'(arb_busy),    32'(c <= 16));
            if (c == 17) xmit_mute = 1'b0;
        end
        @(negedge clk);
        checkOutput("wd_retry_tx_start",   32'(tx_start),    32'd1);
        checkOutput("wd_retry_grant_id",   32'(grant_id),    32'd2);
        checkOutput("wd_timeout_err_once", 32'(timeout_err), 32'd0);
`else
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            checkOutput($sformatf("nowd_timeout_err_c%0d", c), 32'(timeout_err), 32'd0);
            checkOutput($sformatf("nowd_arb_busy_c%0d", c),    32'(arb_busy),    32'd1);
            checkOutput($sformatf("nowd_tx_start_c%0d", c),    32'(tx_start),    32'd0);
        end
        xmit_mute  = 1'b0;
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        force_busy = 1'b0;
`endif
        waitIdle();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
